// File: rtl/axis_chirp_deframer.sv
// Purpose : range-gate deframer for FFT output frames; checks frame length against cfg_nfft,
//           forwards only bins cfg_bin_first..cfg_bin_last with a relative bin index and regenerated tlast.
// Latency : 1 cycle from accepted input beat to m_axis_tvalid; 1 beat/cycle sustained.
// Backpressure: single output register, s_axis_tready = ~areset & (~m_axis_tvalid | m_axis_tready);
//           discarded beats are accepted whenever the output register is free.
//
// Ports
//   aclk, areset            : clock, synchronous active-high reset
//   cfg_nfft                : frame length = 1 << cfg_nfft (clamped to INDEX_WIDTH)
//   cfg_bin_first/_last     : inclusive bin window forwarded downstream
//   err_short / err_long    : one-cycle registered pulses for early / missing tlast
//   frame_count             : count of well-formed frames
//   s_axis_*                : FFT sample stream in
//   m_axis_*                : gated stream out, tuser = bin index relative to cfg_bin_first
//
// Build option: define AXIS_CHIRP_DEFRAMER_FCNT_EN to implement frame_count; otherwise it reads 0.

module axis_chirp_deframer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int INDEX_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [4:0]                  cfg_nfft,
    input  logic [INDEX_WIDTH-1:0]      cfg_bin_first,
    input  logic [INDEX_WIDTH-1:0]      cfg_bin_last,
    output logic                        err_short,
    output logic                        err_long,
    output logic [31:0]                 frame_count,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [INDEX_WIDTH-1:0]      m_axis_tuser,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [INDEX_WIDTH-1:0]      idx_q, idx_d;
    logic [INDEX_WIDTH-1:0]      n_last_q, n_last_d;
    logic [INDEX_WIDTH-1:0]      w_first_q, w_first_d;
    logic [INDEX_WIDTH-1:0]      w_last_q, w_last_d;

    logic                        m_vld_q, m_vld_d;
    logic [AXIS_TDATA_WIDTH-1:0] m_dat_q, m_dat_d;
    logic [INDEX_WIDTH-1:0]      m_user_q, m_user_d;
    logic                        m_last_q, m_last_d;
    logic                        err_short_q, err_short_d;
    logic                        err_long_q, err_long_d;

    // Configuration as it would be latched right now
    logic [4:0]                  nfft_c;
    logic [INDEX_WIDTH-1:0]      cfg_n_last;
    logic [INDEX_WIDTH-1:0]      cfg_w_last;

    // Values in force for the beat currently presented
    logic                        first_beat;
    logic [INDEX_WIDTH-1:0]      eff_n_last;
    logic [INDEX_WIDTH-1:0]      eff_first;
    logic [INDEX_WIDTH-1:0]      eff_last;

    logic                        s_rdy;
    logic                        s_acc;
    logic                        in_win;

    // Shifting all-ones left by INDEX_WIDTH yields zero, so the clamp gives an all-ones n_last.
    always_comb begin
        nfft_c = cfg_nfft;
        if (int'(cfg_nfft) > INDEX_WIDTH) begin
            nfft_c = 5'(INDEX_WIDTH);
        end
        cfg_n_last = ~({INDEX_WIDTH{1'b1}} << nfft_c);
        cfg_w_last = (cfg_bin_last < cfg_n_last) ? cfg_bin_last : cfg_n_last;
    end

    // The first beat of a frame is judged against the live cfg, since the shadow
    // copy only takes that value at the end of the same cycle.
    always_comb begin
        first_beat = (idx_q == '0);
        eff_n_last = first_beat ? cfg_n_last    : n_last_q;
        eff_first  = first_beat ? cfg_bin_first : w_first_q;
        eff_last   = first_beat ? cfg_w_last    : w_last_q;
        in_win     = (idx_q >= eff_first) && (idx_q <= eff_last);
    end

    assign s_rdy = ~areset & (~m_vld_q | m_axis_tready);
    assign s_acc = s_axis_tvalid & s_rdy;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_last_d    = n_last_q;
        w_first_d   = w_first_q;
        w_last_d    = w_last_q;
        m_vld_d     = m_vld_q & ~m_axis_tready;
        m_dat_d     = m_dat_q;
        m_user_d    = m_user_q;
        m_last_d    = m_last_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        if (s_acc) begin
            unique case (state_q)
                ST_SYNC: begin
                    // Reset may land mid-frame; wait for a frame boundary.
                    if (s_axis_tlast) begin
                        state_d = ST_PASS;
                        idx_d   = '0;
                    end
                end

                ST_PASS: begin
                    if (first_beat) begin
                        n_last_d  = cfg_n_last;
                        w_first_d = cfg_bin_first;
                        w_last_d  = cfg_w_last;
                    end

                    // An early tlast inside the window still closes it downstream.
                    if (in_win) begin
                        m_vld_d  = 1'b1;
                        m_dat_d  = s_axis_tdata;
                        m_user_d = idx_q - eff_first;
                        m_last_d = (idx_q == eff_last) | s_axis_tlast;
                    end

                    if (s_axis_tlast) begin
                        idx_d = '0;
                        if (idx_q != eff_n_last) begin
                            err_short_d = 1'b1;
                        end
                    end else if (idx_q == eff_n_last) begin
                        err_long_d = 1'b1;
                        state_d    = ST_DRAIN;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (s_axis_tlast) begin
                        state_d = ST_PASS;
                        idx_d   = '0;
                    end
                end

                default: begin
                    state_d = ST_SYNC;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_SYNC;
            idx_q       <= '0;
            n_last_q    <= '0;
            w_first_q   <= '0;
            w_last_q    <= '0;
            m_vld_q     <= 1'b0;
            m_dat_q     <= '0;
            m_user_q    <= '0;
            m_last_q    <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_last_q    <= n_last_d;
            w_first_q   <= w_first_d;
            w_last_q    <= w_last_d;
            m_vld_q     <= m_vld_d;
            m_dat_q     <= m_dat_d;
            m_user_q    <= m_user_d;
            m_last_q    <= m_last_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

`ifdef AXIS_CHIRP_DEFRAMER_FCNT_EN
    logic [31:0] frame_count_q, frame_count_d;
    logic        good_frame;

    always_comb begin
        good_frame    = s_acc && (state_q == ST_PASS) && s_axis_tlast && (idx_q == eff_n_last);
        frame_count_d = frame_count_q + 32'(good_frame);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

    assign s_axis_tready = s_rdy;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;

endmodule

// File: tb/tb_axis_chirp_deframer.sv
// Purpose : directed self-checking bench for axis_chirp_deframer.
// Latency : n/a (bench).
// Backpressure: m_axis_tready driven always-high, random, or held low depending on phase.

module tb_axis_chirp_deframer;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam int BW = DW + IW + 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic [4:0]    cfg_nfft;
    logic [IW-1:0] cfg_bin_first;
    logic [IW-1:0] cfg_bin_last;
    logic          err_short;
    logic          err_long;
    logic [31:0]   frame_count;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [IW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    always #5 aclk = ~aclk;

    axis_chirp_deframer #(
        .AXIS_TDATA_WIDTH (DW),
        .INDEX_WIDTH      (IW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_nfft      (cfg_nfft),
        .cfg_bin_first (cfg_bin_first),
        .cfg_bin_last  (cfg_bin_last),
        .err_short     (err_short),
        .err_long      (err_long),
        .frame_count   (frame_count),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_beat(input logic [DW-1:0] d, input int u, input logic l);
        return {d, IW'(u), l};
    endfunction

    // Output monitor: captures handshakes, counts error pulses, checks held beats stay put.
    logic [BW-1:0] out_q[$];
    logic [BW-1:0] exp_q[$];
    int            n_short = 0;
    int            n_long  = 0;
    int            n_both  = 0;
    logic          stall_p = 1'b0;
    logic [BW-1:0] stall_beat;

    always @(negedge aclk) begin
        if (areset) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                check_val("hold_vld", m_axis_tvalid, 1);
                check_val("hold_beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, stall_beat);
            end
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
            stall_p    = m_axis_tvalid && !m_axis_tready;
            stall_beat = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
        if (err_short) n_short++;
        if (err_long)  n_long++;
        if (err_short && err_long) n_both++;
    end

    // 0: always ready, 1: random 50%, 2: held low
    int rdy_mode = 0;
    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    logic gap_en = 1'b0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int   guard = 0;
        logic acc   = 1'b0;
        if (gap_en) begin
            repeat ($urandom_range(0, 1)) tick();
        end
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!acc) begin
            @(negedge aclk);
            acc = s_axis_tready;
            tick();
            guard++;
            if (!acc && guard > 1000) begin
                check_val("send_timeout", 0, 1);
                acc = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) send_beat(base + DW'(i), i == n - 1);
    endtask

    task automatic wait_out(input string tag, input int n);
        for (int i = 0; i < 4000 && out_q.size() < n; i++) tick();
        repeat (4) tick();
        check_val({tag, "_count"}, out_q.size(), n);
    endtask

    task automatic check_beat(input string tag, input int k, input logic [BW-1:0] exp);
        if (k < out_q.size()) check_val(tag, out_q[k], exp);
        else                  check_val({tag, "_missing"}, 0, 1);
    endtask

    task automatic clear_mon();
        out_q.delete();
        exp_q.delete();
        n_short = 0;
        n_long  = 0;
        n_both  = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] rd;
        int            fc_exp;

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        cfg_nfft      = 5'd4;
        cfg_bin_first = 16'd2;
        cfg_bin_last  = 16'd5;

        // ---- reset state ----
        repeat (3) tick();
        @(negedge aclk);
        check_val("rst_tvalid", m_axis_tvalid, 0);
        check_val("rst_tready", s_axis_tready, 0);
        check_val("rst_tdata",  m_axis_tdata, 0);
        check_val("rst_tuser",  m_axis_tuser, 0);
        check_val("rst_tlast",  m_axis_tlast, 0);
        check_val("rst_errs",   {err_short, err_long}, 0);
        check_val("rst_fcnt",   frame_count, 0);
        tick();
        areset = 1'b0;
        clear_mon();

        // ---- good frames: partial frame dropped, then 3 x 16 beats, bins 2..5 ----
        send_frame(32'hA000, 5);
        for (int f = 0; f < 3; f++) send_frame(32'h100 * (f + 1), 16);
        wait_out("good", 12);
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 4; k++)
                check_beat("good_beat", f * 4 + k, mk_beat(32'h100 * (f + 1) + 32'(k + 2), k, k == 3));
        check_val("good_errs", n_short + n_long, 0);
`ifdef AXIS_CHIRP_DEFRAMER_FCNT_EN
        fc_exp = 3;
`else
        fc_exp = 0;
`endif
        check_val("good_fcnt", frame_count, 64'(fc_exp));

        // ---- short frame: bins 8..12, tlast at idx 9 ----
        clear_mon();
        cfg_bin_first = 16'd8;
        cfg_bin_last  = 16'd12;
        send_frame(32'h2000, 10);
        wait_out("short", 2);
        check_beat("short_b0", 0, mk_beat(32'h2008, 0, 1'b0));
        check_beat("short_b1", 1, mk_beat(32'h2009, 1, 1'b1));
        check_val("short_err_short", n_short, 1);
        check_val("short_err_long",  n_long, 0);
        send_frame(32'h2100, 16);
        wait_out("short_next", 7);
        for (int k = 0; k < 5; k++)
            check_beat("short_next_beat", 2 + k, mk_beat(32'h2108 + 32'(k), k, k == 4));
        check_val("short_next_err", n_short, 1);

        // ---- long frame: bins 0..15, 20 beats ----
        clear_mon();
        cfg_bin_first = 16'd0;
        cfg_bin_last  = 16'd15;
        send_frame(32'h3000, 20);
        wait_out("long", 16);
        for (int k = 0; k < 16; k++)
            check_beat("long_beat", k, mk_beat(32'h3000 + 32'(k), k, k == 15));
        check_val("long_err_long",  n_long, 1);
        check_val("long_err_short", n_short, 0);
        send_frame(32'h3100, 16);
        wait_out("long_next", 32);
        check_beat("long_next_first", 16, mk_beat(32'h3100, 0, 1'b0));
        check_beat("long_next_last",  31, mk_beat(32'h310F, 15, 1'b1));
        check_val("long_next_err", n_long, 1);

        // ---- config change mid-frame: bin_last 5 -> 7 after idx 3 ----
        clear_mon();
        cfg_bin_first = 16'd2;
        cfg_bin_last  = 16'd5;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h4000 + 32'(i), i == 15);
            if (i == 3) cfg_bin_last = 16'd7;
        end
        send_frame(32'h4100, 16);
        wait_out("cfgchg", 10);
        for (int k = 0; k < 4; k++)
            check_beat("cfgchg_f0", k, mk_beat(32'h4002 + 32'(k), k, k == 3));
        for (int k = 0; k < 6; k++)
            check_beat("cfgchg_f1", 4 + k, mk_beat(32'h4102 + 32'(k), k, k == 5));

        // ---- empty window: first > last, frame consumed silently ----
        clear_mon();
        cfg_bin_first = 16'd9;
        cfg_bin_last  = 16'd3;
        send_frame(32'h5000, 16);
        wait_out("empty", 0);
        check_val("empty_errs", n_short + n_long, 0);

        // ---- reset mid-frame with a held output beat ----
        clear_mon();
        cfg_bin_first = 16'd0;
        cfg_bin_last  = 16'd15;
        rdy_mode = 2;
        tick();
        send_beat(32'h6000, 1'b0);
        @(negedge aclk);
        check_val("rstmid_vld_before", m_axis_tvalid, 1);
        tick();
        areset = 1'b1;
        @(negedge aclk);
        check_val("rstmid_tready", s_axis_tready, 0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        check_val("rstmid_vld_after", m_axis_tvalid, 0);
        rdy_mode = 0;
        tick();
        for (int i = 1; i < 16; i++) send_beat(32'h6000 + 32'(i), i == 15);
        wait_out("rstmid_sync", 0);
        send_frame(32'h6100, 16);
        wait_out("rstmid_resume", 16);
        check_beat("rstmid_first", 0,  mk_beat(32'h6100, 0, 1'b0));
        check_beat("rstmid_last",  15, mk_beat(32'h610F, 15, 1'b1));

        // ---- random backpressure against the gated model, bins 3..10 ----
        clear_mon();
        cfg_bin_first = 16'd3;
        cfg_bin_last  = 16'd10;
        rdy_mode = 1;
        gap_en   = 1'b1;
        for (int f = 0; f < 200; f++) begin
            for (int i = 0; i < 16; i++) begin
                rd = $urandom;
                if (i >= 3 && i <= 10) exp_q.push_back(mk_beat(rd, i - 3, i == 10));
                send_beat(rd, i == 15);
            end
        end
        gap_en = 1'b0;
        wait_out("bp", exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < out_q.size() && out_q[k] !== exp_q[k]) check_val("bp_beat", out_q[k], exp_q[k]);
        end
        check_val("bp_match", (out_q == exp_q), 1);
        check_val("bp_errs", n_short + n_long, 0);
        rdy_mode = 0;
        tick();

        check_val("never_both_err", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
